// File: rtl/shot_scheduler.sv
// shot_scheduler: four-slot shot scheduler with magazine, cooldown, per-frame motion and a registered pixel-hit output.
// Build option: define SHOT_SCHEDULER_AUTO_RELOAD_EN to refill an empty magazine on an idle frame_tick.
module shot_scheduler #(
    parameter int MAX_AMMO = 6,
    parameter int START_Y  = 424,
    parameter int SPEED    = 4,
    parameter int COOLDOWN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire,
    input  logic       reload,
    input  logic       frame_tick,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic [9:0] pos_x,
    output logic [5:0] data,
    output logic       draw,
    output logic [2:0] ammo,
    output logic [3:0] busy
);
    localparam int              CD_W        = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [9:0]      START_Y_V   = 10'(START_Y);
    localparam logic [9:0]      SPEED_V     = 10'(SPEED);
    localparam logic [2:0]      AMMO_V      = 3'(MAX_AMMO);
    localparam logic [CD_W-1:0] COOLDOWN_V  = CD_W'(COOLDOWN);
    localparam logic [5:0]      SHOT_COLOUR = 6'b101010;

    logic [3:0]       active_q, active_d;
    logic [3:0][9:0]  x_q, x_d;
    logic [3:0][9:0]  y_q, y_d;
    logic [2:0]       ammo_q, ammo_d;
    logic [CD_W-1:0]  cd_q, cd_d;
    logic             fire_low_q;
    logic             draw_q;
    logic [5:0]       data_q;

    logic             fire_edge_s;
    logic             launch_s;
    logic             found_s;
    logic             auto_refill_s;
    logic [1:0]       slot_s;
    logic [3:0]       hit_s;

    // Slot, magazine and cooldown next-state.
    always_comb begin
        active_d    = active_q;
        x_d         = x_q;
        y_d         = y_q;
        ammo_d      = ammo_q;
        cd_d        = cd_q;
        slot_s      = 2'd0;
        found_s     = 1'b0;
        // fire_low_q is cleared by reset, so fire must be seen low once after release
        fire_edge_s = fire & fire_low_q;

        for (int i = 0; i < 4; i++) begin
            if (!active_q[i] && !found_s) begin
                slot_s  = 2'(i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end

        launch_s = fire_edge_s && !reload && (ammo_q != 3'd0) &&
                   (cd_q == '0) && found_s;

`ifdef SHOT_SCHEDULER_AUTO_RELOAD_EN
        auto_refill_s = frame_tick && (ammo_q == 3'd0) && (active_q == 4'b0000);
`else
        auto_refill_s = 1'b0;
`endif

        if (frame_tick) begin
            if (cd_q != '0) begin
                cd_d = cd_q - CD_W'(1);
            end else begin
                cd_d = cd_q;
            end
            for (int i = 0; i < 4; i++) begin
                if (active_q[i]) begin
                    if (y_q[i] < SPEED_V) begin
                        active_d[i] = 1'b0;
                    end else begin
                        y_d[i] = y_q[i] - SPEED_V;
                    end
                end else begin
                    active_d[i] = active_q[i];
                end
            end
        end else begin
            cd_d = cd_q;
        end

        // The launched slot was inactive at cycle start, so the motion above never touched it.
        if (launch_s) begin
            active_d[slot_s] = 1'b1;
            x_d[slot_s]      = pos_x;
            y_d[slot_s]      = START_Y_V;
            ammo_d           = ammo_q - 3'd1;
            cd_d             = COOLDOWN_V;
        end else begin
            ammo_d = ammo_q;
        end

        if (reload && (active_q == 4'b0000)) begin
            ammo_d = AMMO_V;
            cd_d   = '0;
        end else if (auto_refill_s) begin
            ammo_d = AMMO_V;
        end else begin
            ammo_d = ammo_d;
        end
    end

    // Per-slot pixel hit test, sums widened to 11 bits so x+8 and y+10 never wrap.
    always_comb begin
        hit_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            hit_s[i] = active_q[i]
                && ({1'b0, hcount} >= {1'b0, x_q[i]})
                && ({1'b0, hcount} <  ({1'b0, x_q[i]} + 11'd8))
                && ({1'b0, vcount} >= {1'b0, y_q[i]})
                && ({1'b0, vcount} <= ({1'b0, y_q[i]} + 11'd10));
        end
    end

    // Slot, magazine, cooldown and fire-history state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q   <= 4'b0000;
            x_q        <= '0;
            y_q        <= {4{START_Y_V}};
            ammo_q     <= AMMO_V;
            cd_q       <= '0;
            fire_low_q <= 1'b0;
        end else begin
            active_q   <= active_d;
            x_q        <= x_d;
            y_q        <= y_d;
            ammo_q     <= ammo_d;
            cd_q       <= cd_d;
            fire_low_q <= ~fire;
        end
    end

    // Registered pixel output, one clock after the hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            draw_q <= 1'b0;
            data_q <= 6'b000000;
        end else begin
            draw_q <= |hit_s;
            data_q <= (|hit_s) ? SHOT_COLOUR : 6'b000000;
        end
    end

    assign busy = active_q;
    assign ammo = ammo_q;
    assign draw = draw_q;
    assign data = data_q;

endmodule

// File: doc/shot_scheduler.md
SHOT_SCHEDULER -- requirements
Module: shot_scheduler

Interface
REQ-001 Parameter MAX_AMMO, default 6: magazine size, range 1..7.
REQ-002 Parameter START_Y, default 424: spawn row of a new shot.
REQ-003 Parameter SPEED, default 4: rows moved up per frame_tick.
REQ-004 Parameter COOLDOWN, default 8: frame_ticks between accepted shots.
REQ-005 clk  in  1  single system clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 fire  in  1  trigger level, synchronous to clk.
REQ-008 reload  in  1  reload request level.
REQ-009 frame_tick  in  1  one-cycle pulse, once per video frame.
REQ-010 hcount, vcount  in  10 each  current pixel coordinates.
REQ-011 pos_x  in  10  crosshair column sampled at launch.
REQ-012 data  out  6  shot pixel colour.
REQ-013 draw  out  1  shot pixel valid.
REQ-014 ammo  out  3  remaining rounds.
REQ-015 busy  out  4  per-slot active flags, bit i = slot i.

Function
REQ-016 Four shot slots, each: active flag, x[9:0], y[9:0], unsigned.
REQ-017 fire edge = fire high this cycle and low the previous cycle; a held fire yields one edge.
REQ-018 Launch on fire edge iff ammo>0, cooldown==0, and at least one slot is inactive at the start of the cycle.
REQ-019 Launch: lowest-index inactive slot gets active=1, x=pos_x, y=START_Y; ammo decrements by 1; cooldown loads COOLDOWN; all in the same clock edge.
REQ-020 Fire edge failing REQ-018 is dropped, not queued; no state changes.
REQ-021 On frame_tick: cooldown decrements if nonzero; each slot active at the start of the cycle with y<SPEED retires (active=0); otherwise y-=SPEED.
REQ-022 A slot launched in a frame_tick cycle is not moved in that cycle.
REQ-023 A slot retiring in a cycle is not available for launch until the next cycle.
REQ-024 reload high with no slot active sets ammo=MAX_AMMO and clears cooldown; reload with any slot active is ignored.
REQ-025 reload and fire edge in the same cycle: reload is evaluated and the fire edge is dropped.
REQ-026 Pixel hit for slot i: active, x<=hcount<x+8, y<=vcount<=y+10; sums computed at 11 bits (no wrap).
REQ-027 draw=1 and data=6'b101010 one clk after a cycle with any slot hit; otherwise draw=0 and data=6'b000000.
REQ-028 busy mirrors slot active flags combinationally from registers; ammo is registered.

Reset
REQ-029 reset low asynchronously clears: all slots inactive, x=0, y=START_Y, ammo=MAX_AMMO, cooldown=0, fire edge history=0, draw=0, data=0.
REQ-030 Reset asserted mid-flight aborts all shots; the first fire edge after release needs fire to be seen low for one cycle after release.

Configuration
REQ-031 Macro SHOT_SCHEDULER_AUTO_RELOAD_EN: defined -> on any frame_tick where ammo==0 and no slot active, ammo loads MAX_AMMO; undefined -> ammo refills only via reload per REQ-024.

Verification
REQ-032 Reset, fire edge pos_x=100 -> slot0 x=100 y=424, ammo 6->5, busy=0001.
REQ-033 Slot0 at y=424, 106 frame_ticks -> y=0 after tick 106; tick 107 retires it, busy=0000.
REQ-034 Fire edges 2 cycles apart -> second dropped (cooldown); after 8 frame_ticks next edge launches into slot1.
REQ-035 Launch 6 shots respecting cooldown -> ammo=0, 7th edge dropped; reload with slots active ignored, reload after all retire -> ammo=6 (with AUTO_RELOAD_EN: refill on first idle frame_tick).
REQ-036 Slot at x=200 y=300, scan hcount=199..208, vcount=300 -> draw high exactly for hcount 200..207, each one cycle later, data=101010.
REQ-037 Reset pulsed with three slots active -> busy=0000, ammo=6, draw=0 immediately.
